// File: rtl/rob_retire_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sys_defs: shared definitions for the ROB retire/rollback controller.
//
// Contents:
//   NUM_ROB          number of ROB entries (from `NUM_ROB, default 8, power of 2)
//   ROB_IDX_W        ROB index width, $clog2(NUM_ROB)
//   ROB_CTRL_STATE_t controller FSM state {IDLE, ROLLBACK}
//   rob_dec()        ROB index decrement with wrap (0 -> NUM_ROB-1)
// ----------------------------------------------------------------------------
`ifndef NUM_ROB
`define NUM_ROB 8
`endif

package sys_defs;

  localparam int NUM_ROB   = `NUM_ROB;
  localparam int ROB_IDX_W = $clog2(NUM_ROB);

  typedef enum logic {
    IDLE     = 1'b0,
    ROLLBACK = 1'b1
  } ROB_CTRL_STATE_t;

  // NUM_ROB is a power of two, so plain modular subtraction wraps correctly.
  function automatic logic [ROB_IDX_W-1:0] rob_dec(input logic [ROB_IDX_W-1:0] idx);
    return idx - ROB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// ----------------------------------------------------------------------------
// rob_retire_ctrl_if: signal bundle between dispatch/CDB/rob_m and the
// retire controller.
//
// Handshake semantics: there is no backpressure on this bundle. Every strobe
// (dispatch_en, cdb_valid, mispredict, retire_r, rollback_valid) is a
// single-cycle event that is consumed in the cycle it is high; its index field
// is only meaningful while the strobe is high. stall_dispatch is the only
// flow-control signal and tells dispatch not to present dispatch_en.
//
// Modports:
//   master  environment side (drives dispatch/CDB/ROB pointers/mispredict)
//   slave   controller side (drives retire/rollback/stall/busy/state_dbg)
// ----------------------------------------------------------------------------
interface rob_retire_ctrl_if;
  import sys_defs::*;

  // dispatch, CDB and ROB pointers
  logic                 dispatch_en;
  logic [ROB_IDX_W-1:0] dispatch_idx;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [ROB_IDX_W-1:0] head_idx;
  logic                 head_valid;
  logic [ROB_IDX_W-1:0] tail_idx;
  logic                 mispredict;
  logic [ROB_IDX_W-1:0] br_rob_idx;

  // controller outputs
  logic                 retire_r;
  logic [ROB_IDX_W-1:0] retire_idx;
  logic                 rollback_valid;
  logic [ROB_IDX_W-1:0] rollback_idx;
  logic                 stall_dispatch;
  logic                 busy;
  ROB_CTRL_STATE_t      state_dbg;

  modport master (
    output dispatch_en, dispatch_idx, cdb_valid, cdb_rob_idx,
           head_idx, head_valid, tail_idx, mispredict, br_rob_idx,
    input  retire_r, retire_idx, rollback_valid, rollback_idx,
           stall_dispatch, busy, state_dbg
  );

  modport slave (
    input  dispatch_en, dispatch_idx, cdb_valid, cdb_rob_idx,
           head_idx, head_valid, tail_idx, mispredict, br_rob_idx,
    output retire_r, retire_idx, rollback_valid, rollback_idx,
           stall_dispatch, busy, state_dbg
  );

endinterface

// File: rtl/rob_retire_ctrl.sv
// ----------------------------------------------------------------------------
// rob_retire_ctrl: sequencing controller for the reorder buffer.
//
// Tracks per-entry completion from the CDB, raises retire_r when the ROB head
// is complete, and on a branch mispredict walks from the youngest entry back
// to (but not including) the branch, one squash per cycle.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   en             global enable; low freezes all state and masks strobes
//   rif            rob_retire_ctrl_if.slave (dispatch, CDB, ROB pointers,
//                  mispredict in; retire/rollback/stall/busy/state_dbg out)
//   retire_count   (RETIRE_CNT_EN only) number of retires since reset
//   squash_count   (RETIRE_CNT_EN only) number of squashes since reset
//
// Optional feature macro: RETIRE_CNT_EN adds retire_count / squash_count.
// ----------------------------------------------------------------------------
module rob_retire_ctrl
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  rob_retire_ctrl_if.slave rif
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]      retire_count,
  output logic [31:0]      squash_count
`endif
);

  ROB_CTRL_STATE_t      state, state_n;
  logic [ROB_IDX_W-1:0] walk, walk_n;
  logic [ROB_IDX_W-1:0] br_q, br_n;
  logic [NUM_ROB-1:0]   complete, complete_n;

  logic                 run;
  logic                 retire_r;
  logic                 rollback_valid;
  logic [ROB_IDX_W-1:0] tail_m1;
  logic [ROB_IDX_W-1:0] walk_m1;

  // Reset masks the strobes so the reset cycle itself shows all outputs 0,
  // even while the state register still holds ROLLBACK.
  assign run            = en & ~reset;
  assign tail_m1        = rob_dec(rif.tail_idx);
  assign walk_m1        = rob_dec(walk);

  assign retire_r       = run & (state == IDLE) & rif.head_valid & complete[rif.head_idx];
  assign rollback_valid = run & (state == ROLLBACK);

  assign rif.retire_r       = retire_r;
  assign rif.retire_idx     = rif.head_idx;
  assign rif.rollback_valid = rollback_valid;
  assign rif.rollback_idx   = walk;
  assign rif.stall_dispatch = run & ((state == ROLLBACK) | (rif.mispredict & (state == IDLE)));
  assign rif.busy           = ~reset & (state == ROLLBACK);
  assign rif.state_dbg      = state;

  // Next-state / walk pointer
  always_comb begin
    state_n = state;
    walk_n  = walk;
    br_n    = br_q;
    if (en) begin
      case (state)
        IDLE: begin
          if (rif.mispredict) begin
            br_n   = rif.br_rob_idx;
            walk_n = tail_m1;
            // Branch already youngest: nothing younger to squash.
            if (tail_m1 != rif.br_rob_idx) state_n = ROLLBACK;
          end
        end
        ROLLBACK: begin
          // A mispredict here is younger than br_q and is ignored.
          walk_n = walk_m1;
          if (walk_m1 == br_q) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Completion vector: sets first, then clears, so a clear wins on collision.
  always_comb begin
    complete_n = complete;
    if (en) begin
      if (rif.cdb_valid)   complete_n[rif.cdb_rob_idx]  = 1'b1;
      if (rif.dispatch_en) complete_n[rif.dispatch_idx] = 1'b0;
      if (retire_r)        complete_n[rif.head_idx]     = 1'b0;
      if (rollback_valid)  complete_n[walk]             = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      walk     <= '0;
      br_q     <= '0;
      complete <= '0;
    end else begin
      state    <= state_n;
      walk     <= walk_n;
      br_q     <= br_n;
      complete <= complete_n;
    end
  end

`ifdef RETIRE_CNT_EN
  // retire_r / rollback_valid already include en, so the counters hold when en=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count <= '0;
      squash_count <= '0;
    end else begin
      if (retire_r)       retire_count <= retire_count + 32'd1;
      if (rollback_valid) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rob_retire_ctrl: directed testbench for rob_retire_ctrl.
// The stimulus thread pushes expected retire / rollback events and per-cycle
// stall/busy values into queues; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_rob_retire_ctrl;
  import sys_defs::*;

  localparam int RW = 16 + ROB_IDX_W;   // {cycle[15:0], idx}

  logic clock;
  logic reset;
  logic en;
  int   cyc;
  logic mon_on;

  int vectors;
  int miscompares;

  logic [RW-1:0] exp_ret_q[$];
  logic [RW-1:0] exp_rb_q[$];
  logic [17:0]   exp_ctl_q[$];          // {cycle[15:0], stall, busy}

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_count;
  logic [31:0] squash_count;
`endif

  rob_retire_ctrl_if rif ();

  rob_retire_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .en           (en),
    .rif          (rif)
`ifdef RETIRE_CNT_EN
    ,
    .retire_count (retire_count),
    .squash_count (squash_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int c, input int idx);
    logic [15:0]          c16;
    logic [ROB_IDX_W-1:0] i;
    c16 = c[15:0];
    i   = idx[ROB_IDX_W-1:0];
    return {c16, i};
  endfunction

  task automatic push_ret(input int c, input int idx);
    exp_ret_q.push_back(mk(c, idx));
  endtask

  task automatic push_rb(input int c, input int idx);
    exp_rb_q.push_back(mk(c, idx));
  endtask

  // Record this cycle's expected stall/busy, then advance to just after the
  // next rising edge, where inputs for the following cycle are driven.
  task automatic tick(input logic es, input logic eb);
    logic [15:0] c16;
    c16 = cyc[15:0];
    exp_ctl_q.push_back({c16, es, eb});
    @(posedge clock);
    #1;
  endtask

  function automatic logic [ROB_IDX_W-1:0] ix(input int v);
    return v[ROB_IDX_W-1:0];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (mon_on) begin
      logic [17:0]   ectl;
      logic [RW-1:0] e, a;
      logic [15:0]   c16;
      c16 = cyc[15:0];

      if (exp_ctl_q.size() == 0) chk("ctl_queue_empty", 32'd1, 32'd0);
      else begin
        ectl = exp_ctl_q.pop_front();
        chk("stall_busy", {14'd0, c16, rif.stall_dispatch, rif.busy}, {14'd0, ectl});
      end

      a = {c16, rif.retire_idx};
      if (rif.retire_r) begin
        if (exp_ret_q.size() == 0) chk("unexpected_retire", 32'(a), 32'd0);
        else begin
          e = exp_ret_q.pop_front();
          chk("retire", 32'(a), 32'(e));
        end
      end else if (exp_ret_q.size() != 0 && exp_ret_q[0][RW-1:ROB_IDX_W] == c16) begin
        e = exp_ret_q.pop_front();
        chk("missing_retire", 32'd0, 32'(e));
      end

      a = {c16, rif.rollback_idx};
      if (rif.rollback_valid) begin
        if (exp_rb_q.size() == 0) chk("unexpected_rollback", 32'(a), 32'd0);
        else begin
          e = exp_rb_q.pop_front();
          chk("rollback", 32'(a), 32'(e));
        end
      end else if (exp_rb_q.size() != 0 && exp_rb_q[0][RW-1:ROB_IDX_W] == c16) begin
        e = exp_rb_q.pop_front();
        chk("missing_rollback", 32'd0, 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    mon_on = 1'b0;
    reset = 1'b1;
    en = 1'b1;
    rif.dispatch_en = 1'b0;  rif.dispatch_idx = '0;
    rif.cdb_valid   = 1'b0;  rif.cdb_rob_idx  = '0;
    rif.head_idx    = '0;    rif.head_valid   = 1'b0;
    rif.tail_idx    = '0;
    rif.mispredict  = 1'b0;  rif.br_rob_idx   = '0;

    @(posedge clock);
    #1;
    mon_on = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
`ifdef RETIRE_CNT_EN
    chk("retire_count_reset", retire_count, 32'd0);
    chk("squash_count_reset", squash_count, 32'd0);
`endif

    // Idle with a valid head and nothing complete: no retires.
    rif.head_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rif.head_idx = ix(i);
      tick(1'b0, 1'b0);
    end

    // Dispatch 0,1,2; complete 1 then 0; retire 0 then 1; 2 never retires.
    rif.head_idx = ix(0);
    rif.dispatch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rif.dispatch_idx = ix(i);
      tick(1'b0, 1'b0);
    end
    rif.dispatch_en = 1'b0;
    rif.cdb_valid = 1'b1;
    rif.cdb_rob_idx = ix(1);
    tick(1'b0, 1'b0);
    rif.cdb_rob_idx = ix(0);
    push_ret(cyc + 1, 0);
    tick(1'b0, 1'b0);
    rif.cdb_valid = 1'b0;
    push_ret(cyc + 1, 1);
    tick(1'b0, 1'b0);                       // retire 0
    rif.head_idx = ix(1);
    tick(1'b0, 1'b0);                       // retire 1
    rif.head_idx = ix(2);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rif.head_valid = 1'b0;

    // Same-cycle dispatch and CDB on slot 3: the clear wins.
    rif.dispatch_en = 1'b1;  rif.dispatch_idx = ix(3);
    rif.cdb_valid   = 1'b1;  rif.cdb_rob_idx  = ix(3);
    tick(1'b0, 1'b0);
    rif.dispatch_en = 1'b0;
    rif.cdb_valid = 1'b0;
    rif.head_valid = 1'b1;
    rif.head_idx = ix(3);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rif.cdb_valid = 1'b1;
    push_ret(cyc + 1, 3);
    tick(1'b0, 1'b0);
    rif.cdb_valid = 1'b0;
    tick(1'b0, 1'b0);                       // retire 3
    rif.head_valid = 1'b0;
    tick(1'b0, 1'b0);

    // tail=6, br=2: squash 5,4,3; CDB still applied, retire held off until IDLE.
    rif.tail_idx = ix(6);
    rif.br_rob_idx = ix(2);
    rif.mispredict = 1'b1;
    push_rb(cyc + 1, 5);
    push_rb(cyc + 2, 4);
    push_rb(cyc + 3, 3);
    tick(1'b1, 1'b0);
    rif.mispredict = 1'b0;
    tick(1'b1, 1'b1);                       // squash 5
    rif.cdb_valid = 1'b1;
    rif.cdb_rob_idx = ix(0);
    rif.head_valid = 1'b1;
    rif.head_idx = ix(0);
    tick(1'b1, 1'b1);                       // squash 4
    rif.cdb_valid = 1'b0;
    push_ret(cyc + 1, 0);
    tick(1'b1, 1'b1);                       // squash 3
    tick(1'b0, 1'b0);                       // retire 0
    rif.head_valid = 1'b0;

    // Wrap: tail=1, br=5 -> 0,7,6 with a two-cycle en=0 pause after 0.
    rif.tail_idx = ix(1);
    rif.br_rob_idx = ix(5);
    rif.mispredict = 1'b1;
    push_rb(cyc + 1, 0);
    push_rb(cyc + 4, 7);
    push_rb(cyc + 5, 6);
    tick(1'b1, 1'b0);
    rif.mispredict = 1'b0;
    tick(1'b1, 1'b1);                       // squash 0
    en = 1'b0;
    rif.mispredict = 1'b1;
    rif.br_rob_idx = ix(7);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    en = 1'b1;
    rif.br_rob_idx = ix(3);                 // younger mispredict, ignored
    rif.tail_idx = ix(4);
    tick(1'b1, 1'b1);                       // squash 7
    rif.mispredict = 1'b0;
    tick(1'b1, 1'b1);                       // squash 6
    tick(1'b0, 1'b0);

    // Branch is youngest: tail=3, br=2 -> one stall cycle, no squash.
    rif.tail_idx = ix(3);
    rif.br_rob_idx = ix(2);
    rif.mispredict = 1'b1;
    tick(1'b1, 1'b0);
    rif.mispredict = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Full ROB, head=tail=4, branch at head: squash 3,2,1,0,7,6,5.
    rif.head_valid = 1'b1;
    rif.head_idx = ix(4);
    rif.tail_idx = ix(4);
    rif.br_rob_idx = ix(4);
    rif.mispredict = 1'b1;
    for (int k = 0; k < 7; k++) push_rb(cyc + 1 + k, (3 - k + NUM_ROB) % NUM_ROB);
    tick(1'b1, 1'b0);
    rif.mispredict = 1'b0;
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    rif.head_valid = 1'b0;

    // Reset mid-walk: tail=6, br=0; squash 5,4 then reset aborts.
    rif.cdb_valid = 1'b1;
    rif.cdb_rob_idx = ix(7);
    tick(1'b0, 1'b0);
    rif.cdb_valid = 1'b0;
    rif.tail_idx = ix(6);
    rif.br_rob_idx = ix(0);
    rif.mispredict = 1'b1;
    push_rb(cyc + 1, 5);
    push_rb(cyc + 2, 4);
    tick(1'b1, 1'b0);
    rif.mispredict = 1'b0;
    tick(1'b1, 1'b1);                       // squash 5
    tick(1'b1, 1'b1);                       // squash 4
`ifdef RETIRE_CNT_EN
    chk("retire_count_total", retire_count, 32'd4);
    chk("squash_count_total", squash_count, 32'd15);
`endif
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
`ifdef RETIRE_CNT_EN
    chk("retire_count_after_reset", retire_count, 32'd0);
    chk("squash_count_after_reset", squash_count, 32'd0);
`endif
    // complete[7] was set before reset; it must be gone now.
    rif.head_valid = 1'b1;
    rif.head_idx = ix(7);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rif.head_valid = 1'b0;
    tick(1'b0, 1'b0);

    mon_on = 1'b0;
    chk("retire_queue_drained", 32'(exp_ret_q.size()), 32'd0);
    chk("rollback_queue_drained", 32'(exp_rb_q.size()), 32'd0);
    chk("ctl_queue_drained", 32'(exp_ctl_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rob_retire_ctrl.md
Name: rob_retire_ctrl

Overview:
Sequencing controller for the reorder buffer (rob_m).
- Tracks per-entry completion from the CDB and drives the ROB retire strobe when the head entry is complete.
- On a branch mispredict, runs a rollback walk from the youngest entry back to the branch, one entry per cycle, so the map table and free list can be restored.
- Sits between dispatch, the CDB, and rob_m. Its retire output feeds rob_packet_in.r.

Parameters:
NUM_ROB, `NUM_ROB (8), number of ROB entries; must be a power of 2.
ROB_IDX_W, $clog2(NUM_ROB), ROB index width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  global enable; low freezes all state
dispatch_en  in  1  an instruction is written into the ROB tail this cycle (accepted)
dispatch_idx  in  ROB_IDX_W  ROB slot written by this dispatch
cdb_valid  in  1  completion broadcast is valid
cdb_rob_idx  in  ROB_IDX_W  ROB slot of the completing instruction
head_idx  in  ROB_IDX_W  current ROB head (rob_packet_out.head_idx_out)
head_valid  in  1  ROB head entry is valid
tail_idx  in  ROB_IDX_W  current ROB tail (next free slot)
mispredict  in  1  branch mispredict resolved this cycle
br_rob_idx  in  ROB_IDX_W  ROB slot of the mispredicted branch
retire_r  out  1  retire the head this cycle (to rob r)
retire_idx  out  ROB_IDX_W  slot being retired (equals head_idx)
rollback_valid  out  1  squash the entry at rollback_idx this cycle
rollback_idx  out  ROB_IDX_W  slot being squashed (youngest first)
stall_dispatch  out  1  dispatch must not proceed
busy  out  1  FSM is in ROLLBACK

Behaviour:
Reset: complete[] all 0, state IDLE, walk pointer 0. All outputs are 0.

en=0:
- No register updates.
- retire_r, rollback_valid and stall_dispatch are all 0.
- busy reflects the held state.

Completion vector (registered, NUM_ROB bits):
- cdb_valid sets complete[cdb_rob_idx].
- dispatch_en clears complete[dispatch_idx].
- retire_r clears complete[head_idx].
- rollback_valid clears complete[rollback_idx].
- When clears and sets hit the same index in one cycle, the clear wins.

Retire (combinational from registered state):
- retire_r = en & state==IDLE & head_valid & complete[head_idx].
- retire_idx = head_idx.
- At most one retire per cycle.
- A CDB set in cycle n can first retire in cycle n+1.

FSM states: IDLE, ROLLBACK.
- IDLE, with mispredict & en:
  - Latch br_rob_idx into br_q and set walk = tail_idx-1 (mod NUM_ROB).
  - If tail_idx-1 == br_rob_idx (the branch is the youngest entry), stay in IDLE with zero rollback cycles.
  - Otherwise go to ROLLBACK.
  - retire_r remains legal in the mispredict cycle, because the head is older than or equal to the branch.
- ROLLBACK, each enabled cycle:
  - rollback_valid=1 and rollback_idx=walk; then walk <= walk-1 (mod, wraps 0 -> NUM_ROB-1).
  - If walk-1 == br_q, next state is IDLE.
  - Exactly (tail_idx-1-br_rob_idx) mod NUM_ROB rollback cycles are issued. The branch itself is never squashed.
- In ROLLBACK: mispredict is ignored (only the oldest mispredict is handled; the branch unit guarantees this), retire_r=0, and cdb sets are still applied.
- stall_dispatch = (state==ROLLBACK) | (mispredict & en & state==IDLE).
- busy = (state==ROLLBACK).
- Full ROB (tail==head, all valid): the walk starts at head-1 and wraps correctly.
- Reset during ROLLBACK aborts the walk: IDLE, complete cleared, no further rollback_valid.

Optional Feature:
RETIRE_CNT_EN
- Defined: adds output retire_count (32-bit).
  - Increments on each retire_r=1.
  - Holds when en=0; resets to 0.
  - Also adds output squash_count (32-bit), which increments on each rollback_valid=1.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package sys_defs: `NUM_ROB, ROB_IDX_W, and the typedef enum ROB_CTRL_STATE_t {IDLE, ROLLBACK}.
- A shared ROB_CTRL_PACKET_IN / ROB_CTRL_PACKET_OUT struct pair in sys_defs is optional.
- No sub-module; the FSM and the completion vector stay in a single module.

Test Plan:
- Reset then idle: retire_r=0, rollback_valid=0, complete=0; head_valid=1 with no CDB keeps retire_r=0 for 10 cycles.
- Dispatch idx 0,1,2; CDB idx 1, then idx 0: retire_r=1 at idx 0 one cycle after the CDB for 0; retire at idx 1 the next cycle; no retire at idx 2.
- Same-cycle dispatch_en idx 3 with cdb_valid idx 3: complete[3]=0 (clear wins).
- tail_idx=6, mispredict br=2: rollback_idx 5,4,3 on three consecutive cycles; stall_dispatch high for 4 cycles; then IDLE.
- Wrap case: tail_idx=1, br=5: rollback_idx 0,7,6. Branch-youngest case: tail_idx=3, br=2: zero rollback cycles, stall for 1 cycle only.
- Assert en=0 mid-ROLLBACK for 2 cycles: rollback_idx sequence resumes unchanged. Assert reset mid-ROLLBACK: immediate IDLE; with RETIRE_CNT_EN, counters read 0.
